// File: rtl/pkg_ula.sv
// Shared ULA definitions: operand width, divider state encoding, div-by-zero quotient.
package pkg_ula;

  localparam int unsigned LARGURA_ULA = 4;

  localparam logic [0:0] OCIOSO  = 1'b0;
  localparam logic [0:0] CALCULA = 1'b1;

  localparam logic [LARGURA_ULA-1:0] QUOC_DIV0 = 4'hF;

endpackage : pkg_ula

// File: rtl/subtrator_4bits.sv
// 4-bit unsigned subtractor: diferenca_c = a - b (mod 16).
// Ports:
//   a, b         : minuend, subtrahend
//   diferenca_c  : difference (combinational)
//   borrow_out_c : 1 when no borrow occurred, i.e. a >= b (combinational)
module subtrator_4bits (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] diferenca_c,
  output logic       borrow_out_c
);

  logic [4:0] soma_c;

  // Two's-complement add; the carry out is the "no borrow" flag.
  always_comb begin
    soma_c       = 5'({1'b0, a}) + 5'({1'b0, ~b}) + 5'd1;
    diferenca_c  = soma_c[3:0];
    borrow_out_c = soma_c[4];
  end

endmodule : subtrator_4bits

// File: rtl/divisor_sequencial_4bits.sv
// Sequential 4-bit unsigned restoring divider, one trial subtraction per cycle.
// Ports:
//   clk, rst_n  : clock (rising edge), async active-low reset
//   start       : request, accepted only while idle
//   a, b        : dividend, divisor (sampled on the accepting edge)
//   busy        : iterations in progress
//   done        : one-cycle pulse when results become valid
//   quociente   : quotient, held until the next accepted start
//   resto       : remainder, held until the next accepted start
//   erro_div0   : last accepted operation had b = 0
module divisor_sequencial_4bits
  import pkg_ula::*;
#(
  parameter int unsigned LARGURA = LARGURA_ULA
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [LARGURA-1:0] a,
  input  logic [LARGURA-1:0] b,
  output logic               busy,
  output logic               done,
  output logic [LARGURA-1:0] quociente,
  output logic [LARGURA-1:0] resto,
  output logic               erro_div0
);

  // The trial subtractor is 4-bit only.
  if (LARGURA != 4) begin : g_largura_invalida
    $error("divisor_sequencial_4bits: LARGURA must be 4");
  end

  logic [0:0]         state_q, state_d;
  logic [LARGURA-1:0] q_q, q_d;
  logic [LARGURA-1:0] d_q, d_d;
  logic [LARGURA-1:0] r_q, r_d;
  logic [1:0]         cont_q, cont_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [LARGURA-1:0] quoc_q, quoc_d;
  logic [LARGURA-1:0] resto_q, resto_d;
  logic               erro_q, erro_d;

  logic [LARGURA-1:0] trial_c;
  logic [LARGURA-1:0] diferenca_c;
  logic               sem_borrow_c;
  logic               r_msb_unused;

  // R stays below 8 before every shift, so its MSB never enters the trial value.
  assign trial_c      = {r_q[LARGURA-2:0], q_q[LARGURA-1]};
  assign r_msb_unused = r_q[LARGURA-1];

  subtrator_4bits u_subtrator (
    .a            (trial_c),
    .b            (d_q),
    .diferenca_c  (diferenca_c),
    .borrow_out_c (sem_borrow_c)
  );

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= OCIOSO;
      q_q     <= '0;
      d_q     <= '0;
      r_q     <= '0;
      cont_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quoc_q  <= '0;
      resto_q <= '0;
      erro_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      d_q     <= d_d;
      r_q     <= r_d;
      cont_q  <= cont_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      quoc_q  <= quoc_d;
      resto_q <= resto_d;
      erro_q  <= erro_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    d_d     = d_q;
    r_d     = r_q;
    cont_d  = cont_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    quoc_d  = quoc_q;
    resto_d = resto_q;
    erro_d  = erro_q;

    case (state_q)
      OCIOSO: begin
        if (start) begin
          if (b == '0) begin
            // Division by zero resolves immediately without iterating.
            quoc_d  = QUOC_DIV0;
            resto_d = a;
            erro_d  = 1'b1;
            done_d  = 1'b1;
          end else begin
            q_d     = a;
            d_d     = b;
            r_d     = '0;
            cont_d  = '0;
            erro_d  = 1'b0;
            busy_d  = 1'b1;
            state_d = CALCULA;
          end
        end
      end
      CALCULA: begin
        if (sem_borrow_c) begin
          r_d = diferenca_c;
          q_d = {q_q[LARGURA-2:0], 1'b1};
        end else begin
          r_d = trial_c;
          q_d = {q_q[LARGURA-2:0], 1'b0};
        end
        cont_d = cont_q + 2'd1;
        if (cont_q == 2'd3) begin
          quoc_d  = q_d;
          resto_d = r_d;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = OCIOSO;
        end
      end
    endcase
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quociente = quoc_q;
  assign resto     = resto_q;
  assign erro_div0 = erro_q;

endmodule : divisor_sequencial_4bits

// File: tb/tb_divisor_sequencial_4bits.sv
// Directed bench for divisor_sequencial_4bits with exact-latency checks.
module tb_divisor_sequencial_4bits;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic       busy;
  logic       done;
  logic [3:0] quociente;
  logic [3:0] resto;
  logic       erro_div0;

  int n_checks;
  int n_errors;

  logic [3:0] prev_q;
  logic [3:0] prev_r;

  divisor_sequencial_4bits dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .quociente (quociente),
    .resto     (resto),
    .erro_div0 (erro_div0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] esp);
    n_checks++;
    if (obs !== esp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, esp);
    end
  endtask

  // Issues one request at a negedge and follows it cycle by cycle to its done pulse.
  // Returns at the negedge where done is observed high, so the next call starts in
  // the done cycle. With intruso set, a second start is pulsed while busy.
  task automatic op(input logic [3:0] av, input logic [3:0] bv,
                    input logic [3:0] eq, input logic [3:0] er, input logic ee,
                    input bit intruso);
    start = 1'b1;
    a     = av;
    b     = bv;
    @(negedge clk);
    start = 1'b0;
    if (bv != 4'd0) begin
      chk("hold_q_at_accept", 8'(quociente), 8'(prev_q));
      chk("hold_r_at_accept", 8'(resto), 8'(prev_r));
      for (int i = 0; i < 4; i++) begin
        if (i > 0) @(negedge clk);
        if (intruso && i == 1) begin
          start = 1'b1;
          a     = 4'd1;
          b     = 4'd1;
        end
        if (intruso && i == 2) start = 1'b0;
        chk("busy_iter", 8'(busy), 8'd1);
        chk("done_iter", 8'(done), 8'd0);
        chk("erro_iter", 8'(erro_div0), 8'd0);
      end
      @(negedge clk);
      start = 1'b0;
    end
    chk("done_pulse", 8'(done), 8'd1);
    chk("busy_at_done", 8'(busy), 8'd0);
    chk("quociente", 8'(quociente), 8'(eq));
    chk("resto", 8'(resto), 8'(er));
    chk("erro_div0", 8'(erro_div0), 8'(ee));
    prev_q = eq;
    prev_r = er;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    prev_q   = 4'h0;
    prev_r   = 4'h0;
    rst_n    = 1'b0;
    start    = 1'b0;
    a        = 4'h0;
    b        = 4'h0;

    #12;
    chk("rst_busy", 8'(busy), 8'd0);
    chk("rst_done", 8'(done), 8'd0);
    chk("rst_quoc", 8'(quociente), 8'd0);
    chk("rst_resto", 8'(resto), 8'd0);
    chk("rst_erro", 8'(erro_div0), 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    op(4'd13, 4'd4, 4'd3,  4'd1, 1'b0, 1'b0);
    op(4'd15, 4'd1, 4'd15, 4'd0, 1'b0, 1'b0);
    op(4'd7,  4'd9, 4'd0,  4'd7, 1'b0, 1'b0);
    op(4'd9,  4'd3, 4'd3,  4'd0, 1'b0, 1'b0);
    op(4'd6,  4'd0, 4'hF,  4'd6, 1'b1, 1'b0);
    op(4'd8,  4'd2, 4'd4,  4'd0, 1'b0, 1'b0);
    op(4'd14, 4'd3, 4'd4,  4'd2, 1'b0, 1'b1);
    op(4'd10, 4'd5, 4'd2,  4'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk("done_single_cycle", 8'(done), 8'd0);
    chk("quoc_held_idle", 8'(quociente), 8'd2);

    // Abort mid-operation with an asynchronous reset.
    start = 1'b1;
    a     = 4'd12;
    b     = 4'd5;
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 8'(busy), 8'd0);
    chk("abort_done", 8'(done), 8'd0);
    chk("abort_quoc", 8'(quociente), 8'd0);
    chk("abort_resto", 8'(resto), 8'd0);
    chk("abort_erro", 8'(erro_div0), 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_abort_done", 8'(done), 8'd0);
      chk("post_abort_busy", 8'(busy), 8'd0);
    end
    prev_q = 4'h0;
    prev_r = 4'h0;

    // All operand pairs, issued back to back.
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        if (ib == 0)
          op(4'(ia), 4'd0, 4'hF, 4'(ia), 1'b1, 1'b0);
        else
          op(4'(ia), 4'(ib), 4'(ia / ib), 4'(ia % ib), 1'b0, 1'b0);
      end
    end
    @(negedge clk);
    chk("final_done_low", 8'(done), 8'd0);
    chk("final_busy_low", 8'(busy), 8'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_divisor_sequencial_4bits
